// File: rtl/qcv_controller.sv
// qcv_controller: pipeline control FSM for the qcv core.
// Sequences boot, takes synchronous exceptions and MRET in DECODE,
// drives IF PC redirects and the CSR trap-save interface.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE_RST   | out of reset, waiting for fetch_enable_i
// RESET_WAIT | boot delay, counts BOOT_DELAY cycles
// BOOT_SET   | one cycle: init mtvec, redirect IF to boot address
// DECODE     | normal operation, traps and MRET resolved combinationally
// FLUSH      | one cycle bubble after a redirect, all events ignored
module qcv_controller #(
    parameter int BOOT_DELAY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_id_i,
    input  logic        instr_fetch_err_i,
    input  logic        illegal_insn_i,
    input  logic        ecall_insn_i,
    input  logic        ebreak_insn_i,
    input  logic        mret_insn_i,
    input  logic        lsu_load_err_i,
    input  logic        lsu_store_err_i,
    input  logic [31:0] lsu_addr_last_i,
    output logic        instr_req_o,
    output logic        pc_set_o,
    output logic [1:0]  pc_mux_o,
    output logic        flush_id_o,
    output logic        halt_id_o,
    output logic        csr_mtvec_init_o,
    output logic        csr_save_if_o,
    output logic        csr_save_id_o,
    output logic        csr_save_cause_o,
    output logic [6:0]  csr_mcause_o,
    output logic [31:0] csr_mtval_o,
    output logic        ctrl_busy_o
);

    typedef enum logic [2:0] {
        IDLE_RST   = 3'd0,
        RESET_WAIT = 3'd1,
        BOOT_SET   = 3'd2,
        DECODE     = 3'd3,
        FLUSH      = 3'd4
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

    localparam logic [1:0] PC_BOOT  = 2'b00;
    localparam logic [1:0] PC_MTVEC = 2'b01;
    localparam logic [1:0] PC_MEPC  = 2'b10;

    state_t     state, state_next;
    logic [3:0] dly_cnt, dly_cnt_next;

    // State and boot-delay counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE_RST;
            dly_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            dly_cnt <= dly_cnt_next;
        end
    end

    // Next-state logic plus Moore/Mealy outputs, with trap priority resolution.
    always_comb begin
        state_next       = state;
        dly_cnt_next     = 4'd0;
        instr_req_o      = 1'b0;
        pc_set_o         = 1'b0;
        pc_mux_o         = PC_BOOT;
        flush_id_o       = 1'b0;
        halt_id_o        = 1'b0;
        csr_mtvec_init_o = 1'b0;
        csr_save_if_o    = 1'b0;
        csr_save_id_o    = 1'b0;
        csr_save_cause_o = 1'b0;
        csr_mcause_o     = 7'd0;
        csr_mtval_o      = 32'd0;
        ctrl_busy_o      = (state != IDLE_RST);

        unique case (state)
            IDLE_RST: begin
                if (fetch_enable_i) state_next = RESET_WAIT;
            end
            RESET_WAIT: begin
                if (dly_cnt == BOOT_LAST) state_next = BOOT_SET;
                else dly_cnt_next = dly_cnt + 4'd1;
            end
            BOOT_SET: begin
                csr_mtvec_init_o = 1'b1;
                pc_set_o         = 1'b1;
                pc_mux_o         = PC_BOOT;
                instr_req_o      = 1'b1;
                state_next       = DECODE;
            end
            DECODE: begin
                instr_req_o = 1'b1;
                // Cause/mtval select; a nonzero cause marks a trap.
                if (lsu_load_err_i) begin
                    csr_mcause_o = 7'd5;
                    csr_mtval_o  = lsu_addr_last_i;
                end else if (lsu_store_err_i) begin
                    csr_mcause_o = 7'd7;
                    csr_mtval_o  = lsu_addr_last_i;
                end else if (instr_valid_i && instr_fetch_err_i) begin
                    csr_mcause_o = 7'd1;
                    csr_mtval_o  = pc_id_i;
                end else if (instr_valid_i && illegal_insn_i) begin
                    csr_mcause_o = 7'd2;
                    csr_mtval_o  = instr_i;
                end else if (instr_valid_i && ebreak_insn_i) begin
                    csr_mcause_o = 7'd3;
                    csr_mtval_o  = pc_id_i;
                end else if (instr_valid_i && ecall_insn_i) begin
                    csr_mcause_o = 7'd11;
                    csr_mtval_o  = 32'd0;
                end

                if (csr_mcause_o != 7'd0) begin
                    csr_save_cause_o = 1'b1;
                    csr_save_id_o    = 1'b1;
                    flush_id_o       = 1'b1;
                    halt_id_o        = 1'b1;
                    pc_set_o         = 1'b1;
                    pc_mux_o         = PC_MTVEC;
                    state_next       = FLUSH;
                end else if (instr_valid_i && mret_insn_i) begin
                    pc_set_o   = 1'b1;
                    pc_mux_o   = PC_MEPC;
                    flush_id_o = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                halt_id_o  = 1'b1;
                flush_id_o = 1'b1;
                state_next = DECODE;
            end
            default: state_next = IDLE_RST;
        endcase
    end

endmodule

// File: tb/tb_qcv_controller.sv
// Directed testbench for qcv_controller (BOOT_DELAY=2).
// Inputs change and outputs are checked in the negedge half of each cycle.
module tb_qcv_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_id_i = '0;
    logic        instr_fetch_err_i = 1'b0;
    logic        illegal_insn_i = 1'b0;
    logic        ecall_insn_i = 1'b0;
    logic        ebreak_insn_i = 1'b0;
    logic        mret_insn_i = 1'b0;
    logic        lsu_load_err_i = 1'b0;
    logic        lsu_store_err_i = 1'b0;
    logic [31:0] lsu_addr_last_i = '0;
    logic        instr_req_o, pc_set_o, flush_id_o, halt_id_o;
    logic [1:0]  pc_mux_o;
    logic        csr_mtvec_init_o, csr_save_if_o, csr_save_id_o, csr_save_cause_o;
    logic [6:0]  csr_mcause_o;
    logic [31:0] csr_mtval_o;
    logic        ctrl_busy_o;

    int checks = 0;
    int errors = 0;

    qcv_controller #(.BOOT_DELAY(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_id_i(pc_id_i),
        .instr_fetch_err_i(instr_fetch_err_i), .illegal_insn_i(illegal_insn_i),
        .ecall_insn_i(ecall_insn_i), .ebreak_insn_i(ebreak_insn_i),
        .mret_insn_i(mret_insn_i), .lsu_load_err_i(lsu_load_err_i),
        .lsu_store_err_i(lsu_store_err_i), .lsu_addr_last_i(lsu_addr_last_i),
        .instr_req_o(instr_req_o), .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o),
        .flush_id_o(flush_id_o), .halt_id_o(halt_id_o),
        .csr_mtvec_init_o(csr_mtvec_init_o), .csr_save_if_o(csr_save_if_o),
        .csr_save_id_o(csr_save_id_o), .csr_save_cause_o(csr_save_cause_o),
        .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o),
        .ctrl_busy_o(ctrl_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the control outputs: {busy,req,set,mux[1:0],flush,halt,mtvec,save_if,save_id,save_cause}
    function automatic logic [31:0] ctl();
        return {21'd0, ctrl_busy_o, instr_req_o, pc_set_o, pc_mux_o, flush_id_o,
                halt_id_o, csr_mtvec_init_o, csr_save_if_o, csr_save_id_o, csr_save_cause_o};
    endfunction

    function automatic logic [31:0] exp_ctl(input logic busy, req, set, input logic [1:0] mux,
                                            input logic flush, halt, mtvec, save);
        return {21'd0, busy, req, set, mux, flush, halt, mtvec, 1'b0, save, save};
    endfunction

    task automatic clear_in();
        fetch_enable_i = 0; instr_valid_i = 0; instr_i = '0; pc_id_i = '0;
        instr_fetch_err_i = 0; illegal_insn_i = 0; ecall_insn_i = 0;
        ebreak_insn_i = 0; mret_insn_i = 0; lsu_load_err_i = 0;
        lsu_store_err_i = 0; lsu_addr_last_i = '0;
    endtask

    task automatic next_cyc();
        @(negedge clk_i);
    endtask

    task automatic chk_trap(input string tag, input logic [6:0] cause, input logic [31:0] tval);
        #1;
        chk({tag, "_ctl"}, ctl(), exp_ctl(1, 1, 1, 2'b01, 1, 1, 0, 1));
        chk({tag, "_mcause"}, {25'd0, csr_mcause_o}, {25'd0, cause});
        chk({tag, "_mtval"}, csr_mtval_o, tval);
    endtask

    task automatic chk_flush(input string tag);
        #1;
        chk({tag, "_flush"}, ctl(), exp_ctl(1, 0, 0, 2'b00, 1, 1, 0, 0));
        chk({tag, "_flush_cause"}, {25'd0, csr_mcause_o}, 32'd0);
    endtask

    task automatic chk_decode_idle(input string tag);
        #1;
        chk({tag, "_dec"}, ctl(), exp_ctl(1, 1, 0, 2'b00, 0, 0, 0, 0));
        chk({tag, "_dec_tval"}, csr_mtval_o, 32'd0);
    endtask

    initial begin
        clear_in();
        next_cyc();
        #1;
        chk("reset_ctl", ctl(), 32'd0);
        chk("reset_cause", {25'd0, csr_mcause_o}, 32'd0);
        chk("reset_tval", csr_mtval_o, 32'd0);
        rst_ni = 1;
        next_cyc();
        next_cyc();
        #1 chk("idle_wait", ctl(), 32'd0);

        // Boot: fetch_enable seen in cycle 0, RESET_WAIT 1-2, BOOT_SET 3, DECODE 4.
        next_cyc();
        fetch_enable_i = 1;
        #1 chk("boot_c0", ctl(), 32'd0);
        next_cyc();
        fetch_enable_i = 0;
        #1 chk("boot_c1", ctl(), exp_ctl(1, 0, 0, 2'b00, 0, 0, 0, 0));
        next_cyc();
        #1 chk("boot_c2", ctl(), exp_ctl(1, 0, 0, 2'b00, 0, 0, 0, 0));
        next_cyc();
        #1 chk("boot_c3", ctl(), exp_ctl(1, 1, 1, 2'b00, 0, 0, 1, 0));
        next_cyc();
        chk_decode_idle("boot_c4");

        // Valid instruction with no event, and MRET without valid: no action.
        next_cyc();
        instr_valid_i = 1; pc_id_i = 32'h80;
        chk_decode_idle("plain");
        instr_valid_i = 0; mret_insn_i = 1;
        chk_decode_idle("mret_novalid");

        // Illegal instruction.
        next_cyc();
        clear_in();
        instr_valid_i = 1; illegal_insn_i = 1; instr_i = 32'hFFFF_FFFF; pc_id_i = 32'h100;
        chk_trap("illegal", 7'd2, 32'hFFFF_FFFF);
        next_cyc();
        clear_in();
        chk_flush("illegal");
        next_cyc();
        chk_decode_idle("illegal_back");

        // Store error beats ECALL and MRET; held into FLUSH must not re-trap.
        next_cyc();
        lsu_store_err_i = 1; lsu_addr_last_i = 32'h2004;
        instr_valid_i = 1; ecall_insn_i = 1; mret_insn_i = 1; pc_id_i = 32'h104;
        chk_trap("prio_store", 7'd7, 32'h2004);
        next_cyc();
        chk_flush("prio_store");
        next_cyc();
        clear_in();
        chk_decode_idle("prio_back");

        // ECALL then MRET.
        next_cyc();
        instr_valid_i = 1; ecall_insn_i = 1; pc_id_i = 32'h200;
        chk_trap("ecall", 7'd11, 32'd0);
        next_cyc();
        clear_in();
        chk_flush("ecall");
        next_cyc();
        instr_valid_i = 1; mret_insn_i = 1; pc_id_i = 32'h204;
        #1;
        chk("mret_ctl", ctl(), exp_ctl(1, 1, 1, 2'b10, 1, 0, 0, 0));
        chk("mret_cause", {25'd0, csr_mcause_o}, 32'd0);
        next_cyc();
        clear_in();
        chk_flush("mret");

        // EBREAK, then a load error pulse during FLUSH is dropped.
        next_cyc();
        instr_valid_i = 1; ebreak_insn_i = 1; pc_id_i = 32'h300;
        chk_trap("ebreak", 7'd3, 32'h300);
        next_cyc();
        clear_in();
        lsu_load_err_i = 1; lsu_addr_last_i = 32'h44;
        chk_flush("flush_load");
        next_cyc();
        clear_in();
        chk_decode_idle("flush_load_back");

        // Load error without a valid instruction; beats a concurrent store error.
        next_cyc();
        lsu_load_err_i = 1; lsu_store_err_i = 1; lsu_addr_last_i = 32'h3008;
        chk_trap("load", 7'd5, 32'h3008);
        next_cyc();
        clear_in();
        chk_flush("load");

        // Fetch error beats illegal; fetch error ignored without instr_valid.
        next_cyc();
        instr_fetch_err_i = 1; illegal_insn_i = 1; instr_i = 32'h1234; pc_id_i = 32'h400;
        chk_decode_idle("fetch_novalid");
        instr_valid_i = 1;
        chk_trap("fetch_err", 7'd1, 32'h400);
        next_cyc();
        clear_in();
        chk_flush("fetch_err");

        // Illegal beats EBREAK.
        next_cyc();
        instr_valid_i = 1; illegal_insn_i = 1; ebreak_insn_i = 1;
        instr_i = 32'h0000_0073; pc_id_i = 32'h500;
        chk_trap("ill_vs_ebrk", 7'd2, 32'h0000_0073);
        next_cyc();
        clear_in();
        chk_flush("ill_vs_ebrk");

        // Async reset while an illegal trap is being signalled.
        next_cyc();
        instr_valid_i = 1; illegal_insn_i = 1; instr_i = 32'hDEAD_BEEF; pc_id_i = 32'h600;
        chk_trap("rst_pre", 7'd2, 32'hDEAD_BEEF);
        #1 rst_ni = 0;
        #1;
        chk("rst_async_ctl", ctl(), 32'd0);
        chk("rst_async_cause", {25'd0, csr_mcause_o}, 32'd0);
        chk("rst_async_tval", csr_mtval_o, 32'd0);
        next_cyc();
        clear_in();
        rst_ni = 1;
        next_cyc();
        next_cyc();
        #1 chk("rst_idle", ctl(), 32'd0);
        fetch_enable_i = 1;
        next_cyc();
        fetch_enable_i = 0;
        #1 chk("rst_reboot", ctl(), exp_ctl(1, 0, 0, 2'b00, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qcv_controller.md
Name: qcv_controller

Overview:
Main pipeline control FSM for the qcv core. It sits between the ID stage, the LSU and the CSR block. It sequences boot, detects synchronous exceptions and MRET, and generates the IF PC redirects. It also drives the CSR block's trap-save inputs: save strobes, cause code and trap value.

Parameters:
BOOT_DELAY, 2, cycles spent in RESET after fetch_enable_i is seen high before BOOT_SET (1..15)

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
fetch_enable_i  input  1  core start permission; sampled only in RESET state
instr_valid_i  input  1  ID holds a valid instruction this cycle
instr_i  input  32  instruction word in ID (for illegal-insn mtval)
pc_id_i  input  32  PC of instruction in ID
instr_fetch_err_i  input  1  bus error on fetch of ID instruction
illegal_insn_i  input  1  ID decoder or CSR block flags illegal instruction
ecall_insn_i  input  1  ECALL in ID
ebreak_insn_i  input  1  EBREAK in ID
mret_insn_i  input  1  MRET in ID
lsu_load_err_i  input  1  load bus error, single-cycle pulse
lsu_store_err_i  input  1  store bus error, single-cycle pulse
lsu_addr_last_i  input  32  address of faulting LSU access
instr_req_o  output  1  IF may fetch
pc_set_o  output  1  IF must load new PC this cycle
pc_mux_o  output  2  PC source: 00 boot, 01 mtvec (exception), 10 mepc (mret)
flush_id_o  output  1  kill instruction in ID / IF buffer
halt_id_o  output  1  stall ID (no register / CSR writeback)
csr_mtvec_init_o  output  1  initialise mtvec from boot address
csr_save_if_o  output  1  save IF PC to mepc; tied 0 in v0.1
csr_save_id_o  output  1  save ID PC to mepc
csr_save_cause_o  output  1  commit trap state into CSRs
csr_mcause_o  output  7  exception cause code
csr_mtval_o  output  32  trap value
ctrl_busy_o  output  1  state is not IDLE_RST

Behaviour:
- States: IDLE_RST, RESET_WAIT, BOOT_SET, DECODE, FLUSH. A 4-bit delay counter is used in RESET_WAIT.
- Reset state: IDLE_RST, counter 0. All outputs are 0, including pc_mux_o=00 and mcause/mtval=0.
- IDLE_RST: stays until fetch_enable_i=1, then moves to RESET_WAIT with counter cleared.
- RESET_WAIT: counter increments each cycle. When counter==BOOT_DELAY-1, moves to BOOT_SET. fetch_enable_i is ignored here.
- BOOT_SET: one cycle, Moore outputs. csr_mtvec_init_o=1, pc_set_o=1, pc_mux_o=00, instr_req_o=1. Moves to DECODE.
- DECODE: instr_req_o=1. All trap outputs are combinational (Mealy) in the same cycle as the event.
- Trap priority, highest first; only the winner acts:
  1. lsu_load_err_i: cause 5, mtval=lsu_addr_last_i.
  2. lsu_store_err_i: cause 7, mtval=lsu_addr_last_i.
  3. instr_valid_i&instr_fetch_err_i: cause 1, mtval=pc_id_i.
  4. instr_valid_i&illegal_insn_i: cause 2, mtval=instr_i.
  5. instr_valid_i&ebreak_insn_i: cause 3, mtval=pc_id_i.
  6. instr_valid_i&ecall_insn_i: cause 11, mtval=0.
- LSU errors (items 1–2) are accepted regardless of instr_valid_i.
- On any trap, for one cycle: csr_save_cause_o=1, csr_save_id_o=1, flush_id_o=1, halt_id_o=1, pc_set_o=1, pc_mux_o=01. Next state is FLUSH.
- MRET (instr_valid_i&mret_insn_i, no trap): pc_set_o=1, pc_mux_o=10, flush_id_o=1, no CSR save. Next state is FLUSH. A trap beats MRET in the same cycle.
- When not trapping, csr_mcause_o and csr_mtval_o are 0. They are valid only while csr_save_cause_o=1.
- FLUSH: one cycle, instr_req_o=0, halt_id_o=1, flush_id_o=1. All trap and MRET inputs are ignored, including LSU pulses (no double fault in v0.1). Moves to DECODE.
- No trap-save or redirect outputs are ever asserted outside DECODE.
- Reset asserted in any state: asynchronous return to IDLE_RST with all outputs 0 immediately. A pending save is discarded.
- csr_save_cause_o is at most one cycle wide per trap, and is never asserted in two consecutive cycles.

Test Plan:
- Boot, BOOT_DELAY=2: reset release, fetch_enable_i=1 at cycle 0 -> RESET_WAIT cycles 1–2; cycle 3 csr_mtvec_init_o=1, pc_set_o=1, pc_mux_o=00; DECODE from cycle 4 with instr_req_o=1.
- Illegal instruction: in DECODE, instr_valid_i=1, illegal_insn_i=1, instr_i=32'hFFFF_FFFF, pc_id_i=32'h100 -> same cycle csr_save_cause_o=1, csr_save_id_o=1, csr_mcause_o=2, csr_mtval_o=32'hFFFF_FFFF, pc_mux_o=01; next cycle FLUSH (instr_req_o=0); then DECODE.
- Priority: lsu_store_err_i=1, lsu_addr_last_i=32'h2004, plus ecall_insn_i=1 and mret_insn_i=1 -> mcause=7, mtval=32'h2004, pc_mux_o=01; single save pulse only.
- ECALL then MRET: ECALL gives mcause=11, mtval=0; after FLUSH, MRET gives pc_set_o=1, pc_mux_o=10, csr_save_cause_o=0.
- Event in FLUSH: lsu_load_err_i pulses during the FLUSH cycle -> no save, no pc_set_o; state returns to DECODE.
- Async reset mid-trap: rst_ni low in the same cycle as illegal_insn_i -> outputs 0 immediately, state IDLE_RST; after release, waits for fetch_enable_i.
